// File: rtl/ysyx_22040759_lsu_mmio.sv
// LSU memory-mapped front end: routes one LSU access at a time either to the
// local CLINT (single-cycle, combinational read) or out to the AXI bridge.
module ysyx_22040759_lsu_mmio #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_addr,
  input  logic [63:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wstrb,
  input  logic [1:0]  lsu_req_size,
  output logic        lsu_rsp_valid,
  output logic [63:0] lsu_rsp_rdata,
  output logic        lsu_rsp_err,
  output logic        clint_wen,
  output logic [31:0] clint_addr,
  output logic [63:0] clint_wdata,
  input  logic [63:0] clint_rdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic [7:0]  bus_req_wstrb,
  output logic [1:0]  bus_req_size,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  typedef enum logic [2:0] {IDLE, CLINT, BUS_REQ, BUS_RSP, RSP} state_t;

  state_t      state, state_nxt;
  logic        rdy_en;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [1:0]  size_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic accept, misalign, clint_hit, req_bad;

  always_comb begin
    misalign = 1'b0;
    case (lsu_req_size)
      2'd1:    misalign = lsu_req_addr[0];
      2'd2:    misalign = |lsu_req_addr[1:0];
      2'd3:    misalign = |lsu_req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign clint_hit = (lsu_req_addr & CLINT_MASK) == CLINT_BASE;
  assign req_bad   = misalign | (clint_hit & lsu_req_wen & (lsu_req_size != 2'd3));
  assign accept    = lsu_req_valid & lsu_req_ready;

  always_comb begin
    state_nxt     = state;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_rdata = 64'd0;
    lsu_rsp_err   = 1'b0;
    clint_wen     = 1'b0;
    clint_addr    = 32'd0;
    clint_wdata   = 64'd0;
    bus_req_valid = 1'b0;
    bus_req_wen   = 1'b0;
    bus_req_addr  = 32'd0;
    bus_req_wdata = 64'd0;
    bus_req_wstrb = 8'd0;
    bus_req_size  = 2'd0;
    case (state)
      IDLE: begin
        lsu_req_ready = rdy_en;
        // Rejected requests also pass through CLINT so that errors answer at
        // the same N+2 latency as a CLINT hit; err_q silences the CLINT port.
        if (accept) state_nxt = (clint_hit | req_bad) ? CLINT : BUS_REQ;
      end
      CLINT: begin
        if (!err_q) begin
          clint_wen   = wen_q;
          clint_addr  = addr_q;
          clint_wdata = wdata_q;
        end
        state_nxt = RSP;
      end
      BUS_REQ: begin
        bus_req_valid = 1'b1;
        bus_req_wen   = wen_q;
        bus_req_addr  = addr_q;
        bus_req_wdata = wdata_q;
        bus_req_wstrb = wstrb_q;
        bus_req_size  = size_q;
        if (bus_req_ready) state_nxt = BUS_RSP;
      end
      BUS_RSP: if (bus_rsp_valid) state_nxt = RSP;
      RSP: begin
        lsu_rsp_valid = 1'b1;
        lsu_rsp_rdata = rdata_q;
        lsu_rsp_err   = err_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdy_en  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
      size_q  <= 2'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          wen_q   <= lsu_req_wen;
          addr_q  <= lsu_req_addr;
          wdata_q <= lsu_req_wdata;
          wstrb_q <= lsu_req_wstrb;
          size_q  <= lsu_req_size;
          rdata_q <= 64'd0;
          err_q   <= req_bad;
        end
        CLINT: if (!err_q) rdata_q <= wen_q ? 64'd0 : clint_rdata;
        BUS_RSP: if (bus_rsp_valid) begin
          rdata_q <= wen_q ? 64'd0 : bus_rsp_rdata;
          err_q   <= bus_rsp_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_lsu_mmio.sv
// Directed bench for ysyx_22040759_lsu_mmio: CLINT, bus, error and reset paths.
module tb_ysyx_22040759_lsu_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wstrb;
  logic [1:0]  lsu_req_size;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  logic        clint_wen;
  logic [31:0] clint_addr;
  logic [63:0] clint_wdata, clint_rdata;
  logic        bus_req_valid, bus_req_ready, bus_req_wen;
  logic [31:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic [1:0]  bus_req_size;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  // mtime-like register visible at a single address
  assign clint_rdata = (clint_addr == 32'h0200_BFF8) ? 64'h1234 : 64'h0;

  ysyx_22040759_lsu_mmio dut (
    .clk(clk), .rst(rst),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_req_size(lsu_req_size),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .clint_wen(clint_wen), .clint_addr(clint_addr),
    .clint_wdata(clint_wdata), .clint_rdata(clint_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_wen(bus_req_wen), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_req_size(bus_req_size),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .bus_rsp_err(bus_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else npass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wstrb, input logic [1:0] size);
    lsu_req_valid = 1'b1;
    lsu_req_wen   = wen;
    lsu_req_addr  = addr;
    lsu_req_wdata = wdata;
    lsu_req_wstrb = wstrb;
    lsu_req_size  = size;
  endtask

  task automatic scramble();
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b1;
    lsu_req_addr  = 32'hFFFF_FFFF;
    lsu_req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
    lsu_req_wstrb = 8'h0F;
    lsu_req_size  = 2'd0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rspv"},  {63'd0, lsu_rsp_valid}, 64'd0);
    chk({tag, "_rspd"},  lsu_rsp_rdata, 64'd0);
    chk({tag, "_cwen"},  {63'd0, clint_wen}, 64'd0);
    chk({tag, "_caddr"}, {32'd0, clint_addr}, 64'd0);
    chk({tag, "_bvld"},  {63'd0, bus_req_valid}, 64'd0);
    chk({tag, "_baddr"}, {32'd0, bus_req_addr}, 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    scramble();
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 64'd0;
    bus_rsp_err   = 1'b0;

    // reset state and ready timing
    #12;
    chk("rst_ready", {63'd0, lsu_req_ready}, 64'd0);
    chk_quiet("rst");
    tick(); #2;
    rst = 1'b1;
    #1;
    chk("rel_ready_pre_edge", {63'd0, lsu_req_ready}, 64'd0);
    tick();
    chk("rel_ready_post_edge", {63'd0, lsu_req_ready}, 64'd1);

    // CLINT read
    req(1'b0, 32'h0200_BFF8, 64'd0, 8'hFF, 2'd3);
    chk("cr_ready", {63'd0, lsu_req_ready}, 64'd1);
    tick(); scramble();
    chk("cr_caddr", {32'd0, clint_addr}, 64'h0200_BFF8);
    chk("cr_cwen", {63'd0, clint_wen}, 64'd0);
    chk("cr_rspv_n1", {63'd0, lsu_rsp_valid}, 64'd0);
    chk("cr_ready_n1", {63'd0, lsu_req_ready}, 64'd0);
    tick();
    chk("cr_rspv", {63'd0, lsu_rsp_valid}, 64'd1);
    chk("cr_rdata", lsu_rsp_rdata, 64'h1234);
    chk("cr_err", {63'd0, lsu_rsp_err}, 64'd0);
    chk("cr_caddr_off", {32'd0, clint_addr}, 64'd0);
    tick();
    chk("cr_idle_ready", {63'd0, lsu_req_ready}, 64'd1);
    chk("cr_idle_rspv", {63'd0, lsu_rsp_valid}, 64'd0);

    // CLINT write
    req(1'b1, 32'h0200_4000, 64'd500, 8'hFF, 2'd3);
    tick(); scramble();
    chk("cw_cwen", {63'd0, clint_wen}, 64'd1);
    chk("cw_cwdata", clint_wdata, 64'd500);
    chk("cw_caddr", {32'd0, clint_addr}, 64'h0200_4000);
    tick();
    chk("cw_cwen_off", {63'd0, clint_wen}, 64'd0);
    chk("cw_rspv", {63'd0, lsu_rsp_valid}, 64'd1);
    chk("cw_rdata", lsu_rsp_rdata, 64'd0);
    chk("cw_err", {63'd0, lsu_rsp_err}, 64'd0);
    tick();

    // bus read with backpressure
    req(1'b0, 32'h8000_0010, 64'd0, 8'h0F, 2'd2);
    tick(); scramble();
    for (int i = 0; i < 3; i++) begin
      chk("br_bvld", {63'd0, bus_req_valid}, 64'd1);
      chk("br_baddr", {32'd0, bus_req_addr}, 64'h8000_0010);
      chk("br_bsize", {62'd0, bus_req_size}, 64'd2);
      chk("br_bwstrb", {56'd0, bus_req_wstrb}, 64'h0F);
      chk("br_bwen", {63'd0, bus_req_wen}, 64'd0);
      chk("br_cwen", {63'd0, clint_wen}, 64'd0);
      tick();
    end
    bus_req_ready = 1'b1;
    chk("br_bvld_r", {63'd0, bus_req_valid}, 64'd1);
    chk("br_baddr_r", {32'd0, bus_req_addr}, 64'h8000_0010);
    tick();
    bus_req_ready = 1'b0;
    chk("br_bvld_off", {63'd0, bus_req_valid}, 64'd0);
    chk("br_baddr_off", {32'd0, bus_req_addr}, 64'd0);
    tick();
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 64'hDEAD_BEEF;
    bus_rsp_err   = 1'b0;
    chk("br_rspv_s", {63'd0, lsu_rsp_valid}, 64'd0);
    tick();
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 64'd0;
    chk("br_rspv", {63'd0, lsu_rsp_valid}, 64'd1);
    chk("br_rdata", lsu_rsp_rdata, 64'hDEAD_BEEF);
    chk("br_err", {63'd0, lsu_rsp_err}, 64'd0);
    tick();

    // misaligned half read
    req(1'b0, 32'h8000_0003, 64'd0, 8'h03, 2'd1);
    tick(); scramble();
    chk_quiet("ma_n1");
    tick();
    chk("ma_bvld", {63'd0, bus_req_valid}, 64'd0);
    chk("ma_rspv", {63'd0, lsu_rsp_valid}, 64'd1);
    chk("ma_err", {63'd0, lsu_rsp_err}, 64'd1);
    chk("ma_rdata", lsu_rsp_rdata, 64'd0);
    tick();

    // CLINT write with non-doubleword size
    req(1'b1, 32'h0200_4000, 64'd77, 8'h0F, 2'd2);
    tick(); scramble();
    chk("cs_cwen", {63'd0, clint_wen}, 64'd0);
    chk("cs_cwdata", clint_wdata, 64'd0);
    chk("cs_bvld", {63'd0, bus_req_valid}, 64'd0);
    tick();
    chk("cs_rspv", {63'd0, lsu_rsp_valid}, 64'd1);
    chk("cs_err", {63'd0, lsu_rsp_err}, 64'd1);
    tick();

    // bus write answered with error
    req(1'b1, 32'h8000_0100, 64'h1122_3344_5566_7788, 8'hFF, 2'd3);
    bus_req_ready = 1'b1;
    tick(); scramble();
    chk("bw_bvld", {63'd0, bus_req_valid}, 64'd1);
    chk("bw_bwen", {63'd0, bus_req_wen}, 64'd1);
    chk("bw_bwdata", bus_req_wdata, 64'h1122_3344_5566_7788);
    chk("bw_bwstrb", {56'd0, bus_req_wstrb}, 64'hFF);
    tick();
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 64'hCAFE;
    bus_rsp_err   = 1'b1;
    tick();
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    bus_rsp_rdata = 64'd0;
    chk("bw_rspv", {63'd0, lsu_rsp_valid}, 64'd1);
    chk("bw_err", {63'd0, lsu_rsp_err}, 64'd1);
    chk("bw_rdata", lsu_rsp_rdata, 64'd0);
    tick();

    // reset while waiting in BUS_RSP, then stray response
    req(1'b0, 32'h8000_0020, 64'd0, 8'hFF, 2'd3);
    bus_req_ready = 1'b1;
    tick(); scramble();
    tick();
    bus_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("ar_ready", {63'd0, lsu_req_ready}, 64'd0);
    chk_quiet("ar");
    tick();
    rst = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 64'hBAD;
    bus_rsp_err   = 1'b1;
    tick();
    chk("ar_ready_post", {63'd0, lsu_req_ready}, 64'd1);
    chk("ar_stray_rspv", {63'd0, lsu_rsp_valid}, 64'd0);
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    bus_rsp_rdata = 64'd0;
    tick();
    chk("ar_stray_rspv2", {63'd0, lsu_rsp_valid}, 64'd0);
    req(1'b0, 32'h0200_BFF8, 64'd0, 8'hFF, 2'd3);
    tick(); scramble();
    tick();
    chk("ar_next_rspv", {63'd0, lsu_rsp_valid}, 64'd1);
    chk("ar_next_rdata", lsu_rsp_rdata, 64'h1234);
    chk("ar_next_err", {63'd0, lsu_rsp_err}, 64'd0);
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
